control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives every select/enable input of the ALU datapath system (RF, ARF, ALU, IR, memory, muxes A/B/C).
- Fetches 16-bit instructions as two byte reads from memory into IR, decodes them, and issues single-cycle execute micro-operations.
- Sits beside the datapath as the initiator of all its control traffic and consumes IROut and the ALU flags.

Parameters:
- OPW, 6, opcode field width (IROut[15:10])

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- IROut  in  16  instruction register contents; [15:10] opcode, [9:8] Rx, [7:6] Ry, [7:0] imm/addr
- ALUOutFlag  in  4  registered flags {Z,C,N,O}
- RF_OutASel, RF_OutBSel  out  3 each  000..011 = R1..R4
- RF_FunSel, ARF_FunSel  out  3 each  000 dec, 001 inc, 010 load, 011 clear
- RF_RegSel  out  4  one-hot enable, bit3 = R1 .. bit0 = R4
- RF_ScrSel  out  4  always 0000
- ALU_FunSel  out  5  10000 pass A, 10100 add A+B
- ALU_WF  out  1  flag write enable
- ARF_OutCSel, ARF_OutDSel  out  2 each  00 PC, 01 AR, 10 SP
- ARF_RegSel  out  3  enables {PC,AR,SP}
- IR_LH  out  1  0 low byte, 1 high byte
- IR_Write  out  1  IR load enable
- Mem_WR  out  1  1 write, 0 read
- Mem_CS  out  1  active-low chip select
- MuxASel, MuxBSel  out  2 each  00 ALUOut, 01 OutC, 10 MemOut, 11 IR[7:0]
- MuxCSel  out  1  0 ALUOut[7:0], 1 ALUOut[15:8]
- Halted  out  1  high in HALT state
- State  out  3  current state, for debug

Behaviour:
- States: INIT, F0, F1, EX, HALT.
- Reset: state <= INIT next edge. During the Reset cycle and every idle field, outputs take default values:
  - RF_RegSel=0, ARF_RegSel=0, IR_Write=0, ALU_WF=0, Mem_CS=1, Mem_WR=0
  - all selects 0, RF_ScrSel=0, Halted=0
- INIT (1 cycle): RF_FunSel=ARF_FunSel=011, RF_RegSel=1111, ARF_RegSel=111; clears R1-R4, PC, AR, SP -> F0.
- F0: ARF_OutDSel=00, Mem_CS=0, Mem_WR=0, IR_Write=1, IR_LH=0, ARF_RegSel=100, ARF_FunSel=001 (PC++) -> F1.
- F1: same as F0 with IR_LH=1 -> EX. IROut is valid from the cycle after F1.
- EX: one cycle, decoded from IROut[15:10], then -> F0 (HALT excepted).
  - 00 LDI: MuxASel=11, RF_FunSel=010, RF_RegSel=onehot(Rx). Upper byte zero-extended by the datapath.
  - 01 LDAR: MuxBSel=11, ARF_FunSel=010, ARF_RegSel=010.
  - 02 LDM: ARF_OutDSel=01, Mem_CS=0, Mem_WR=0, MuxASel=10, RF load Rx.
  - 03 STM: RF_OutASel=Rx, ALU_FunSel=10000, MuxCSel=0, ARF_OutDSel=01, Mem_CS=0, Mem_WR=1.
  - 04 ADD: RF_OutASel=Rx, RF_OutBSel=Ry, ALU_FunSel=10100, ALU_WF=1, MuxASel=00, RF load Rx.
  - 05 BRA: MuxBSel=11, ARF_FunSel=010, ARF_RegSel=100.
  - 06 BNE: as BRA only if ALUOutFlag[3]==0; otherwise defaults (no PC write).
  - 3F HLT: -> HALT.
  - Any other opcode: NOP, defaults, -> F0.
- HALT: defaults, Halted=1; stays until Reset.
- Flags: BNE samples ALUOutFlag in its EX cycle. An ADD immediately before BNE has updated the flags by then (flags write at ADD's EX edge).
- Reset mid-fetch or mid-execute: the asserting edge aborts; no write enable is asserted in that cycle. Sequence restarts at INIT.
- Instruction timing: exactly 3 cycles (F0, F1, EX). PC wraps FFFF->0000 naturally.
- Outputs: Moore-style except EX, which is combinational on IROut/flags. No X on any output after the first Reset edge.

Test Plan:
- Reset held 2 cycles, released -> State INIT for 1 cycle, all RF/ARF RegSel=1111/111 with FunSel=011, then F0 with Mem_CS=0, IR_LH=0, ARF_RegSel=100.
- Memory bytes 0x05,0x00 (LDI R1,0x05) then 0x1F,0xFC (HLT) -> EX cycle MuxASel=11, RF_RegSel=1000; next instruction enters HALT, Halted=1 persists 20 cycles.
- LDI R1,0x05; LDI R2,0xFB; ADD R1,R2 (IR=0x1040) -> ADD EX shows RF_OutASel=000, RF_OutBSel=001, ALU_WF=1. Subsequent BNE 0x20 with Z=1 -> ARF_RegSel=000.
- BNE 0x20 with ALUOutFlag=0000 -> MuxBSel=11, ARF_FunSel=010, ARF_RegSel=100. Next F0 fetch ARF_OutDSel=00.
- LDAR 0x40; STM R1 -> STM EX: ARF_OutDSel=01, Mem_CS=0, Mem_WR=1, MuxCSel=0, ALU_FunSel=10000.
- Reset asserted during F1 -> that cycle IR_Write=0, Mem_CS=1; next state INIT. Opcode 0x2A -> NOP, back to F0 after 1 EX cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the ALU datapath: two-byte fetch into IR, then a
// single execute cycle decoded from IROut[15:10].
module control_sequencer #(
    parameter int OPW = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [15:0]      IROut,
    input  logic [3:0]       ALUOutFlag,
    output logic [2:0]       RF_OutASel,
    output logic [2:0]       RF_OutBSel,
    output logic [2:0]       RF_FunSel,
    output logic [3:0]       RF_RegSel,
    output logic [3:0]       RF_ScrSel,
    output logic [4:0]       ALU_FunSel,
    output logic             ALU_WF,
    output logic [1:0]       ARF_OutCSel,
    output logic [1:0]       ARF_OutDSel,
    output logic [2:0]       ARF_FunSel,
    output logic [2:0]       ARF_RegSel,
    output logic             IR_LH,
    output logic             IR_Write,
    output logic             Mem_WR,
    output logic             Mem_CS,
    output logic [1:0]       MuxASel,
    output logic [1:0]       MuxBSel,
    output logic             MuxCSel,
    output logic             Halted,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_EX   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [OPW-1:0] OP_LDI  = OPW'(0);
    localparam logic [OPW-1:0] OP_LDAR = OPW'(1);
    localparam logic [OPW-1:0] OP_LDM  = OPW'(2);
    localparam logic [OPW-1:0] OP_STM  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_BRA  = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0] OP_HLT  = '1;

    localparam logic [2:0] FUN_INC   = 3'b001;
    localparam logic [2:0] FUN_LOAD  = 3'b010;
    localparam logic [2:0] FUN_CLEAR = 3'b011;

    state_t state_q, state_d;

    logic [OPW-1:0] opcode;
    logic [1:0]     rx, ry;
    logic [3:0]     rx_onehot;
    logic           flag_z;
    logic           unused_bits;

    assign opcode      = IROut[15 -: OPW];
    assign rx          = IROut[9:8];
    assign ry          = IROut[7:6];
    assign rx_onehot   = 4'b1000 >> rx;
    assign flag_z      = ALUOutFlag[3];
    assign unused_bits = ^{IROut[5:0], ALUOutFlag[2:0]};

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        state_d     = state_q;
        RF_OutASel  = 3'b000;
        RF_OutBSel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        RF_ScrSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 3'b000;
        ARF_RegSel  = 3'b000;
        IR_LH       = 1'b0;
        IR_Write    = 1'b0;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;

        // Reset overrides every enable so an aborted cycle never commits a write.
        if (!Reset) begin
            case (state_q)
                S_INIT: begin
                    RF_FunSel  = FUN_CLEAR;
                    ARF_FunSel = FUN_CLEAR;
                    RF_RegSel  = 4'b1111;
                    ARF_RegSel = 3'b111;
                    state_d    = S_F0;
                end
                S_F0, S_F1: begin
                    Mem_CS     = 1'b0;
                    IR_Write   = 1'b1;
                    IR_LH      = (state_q == S_F1);
                    ARF_RegSel = 3'b100;
                    ARF_FunSel = FUN_INC;
                    state_d    = (state_q == S_F0) ? S_F1 : S_EX;
                end
                S_EX: begin
                    state_d = S_F0;
                    case (opcode)
                        OP_LDI: begin
                            MuxASel   = 2'b11;
                            RF_FunSel = FUN_LOAD;
                            RF_RegSel = rx_onehot;
                        end
                        OP_LDAR: begin
                            MuxBSel    = 2'b11;
                            ARF_FunSel = FUN_LOAD;
                            ARF_RegSel = 3'b010;
                        end
                        OP_LDM: begin
                            ARF_OutDSel = 2'b01;
                            Mem_CS      = 1'b0;
                            MuxASel     = 2'b10;
                            RF_FunSel   = FUN_LOAD;
                            RF_RegSel   = rx_onehot;
                        end
                        OP_STM: begin
                            RF_OutASel  = {1'b0, rx};
                            ALU_FunSel  = 5'b10000;
                            ARF_OutDSel = 2'b01;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                        OP_ADD: begin
                            RF_OutASel = {1'b0, rx};
                            RF_OutBSel = {1'b0, ry};
                            ALU_FunSel = 5'b10100;
                            ALU_WF     = 1'b1;
                            RF_FunSel  = FUN_LOAD;
                            RF_RegSel  = rx_onehot;
                        end
                        OP_BRA, OP_BNE: begin
                            if (opcode == OP_BRA || !flag_z) begin
                                MuxBSel    = 2'b11;
                                ARF_FunSel = FUN_LOAD;
                                ARF_RegSel = 3'b100;
                            end
                        end
                        OP_HLT:  state_d = S_HALT;
                        default: ;
                    endcase
                end
                S_HALT: Halted = 1'b1;
                default: state_d = S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected control words are queued as
// each cycle is driven and popped when that cycle's outputs are sampled.
module tb_control_sequencer;

    localparam logic [2:0] S_INIT = 3'd0, S_F0 = 3'd1, S_F1 = 3'd2, S_EX = 3'd3, S_HALT = 3'd4;

    logic        Clock, Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel, State;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
    logic        ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel, Halted;

    control_sequencer #(.OPW(6)) dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
        .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
        .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
        .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halted(Halted), .State(State)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] oa, ob, rff, aff;
        logic [3:0] rrs, rsc;
        logic [4:0] alu;
        logic       wf;
        logic [1:0] oc, od;
        logic [2:0] ars;
        logic       lh, irw, wr, cs;
        logic [1:0] ma, mb;
        logic       mc, hl;
    } ctl_t;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic ctl_t dflt(input logic [2:0] st);
        ctl_t c;
        c    = '0;
        c.cs = 1'b1;
        c.st = st;
        return c;
    endfunction

    function automatic ctl_t fetch(input logic [2:0] st, input logic lh);
        ctl_t c;
        c     = dflt(st);
        c.cs  = 1'b0;
        c.irw = 1'b1;
        c.lh  = lh;
        c.ars = 3'b100;
        c.aff = 3'b001;
        return c;
    endfunction

    function automatic ctl_t init_word();
        ctl_t c;
        c     = dflt(S_INIT);
        c.rff = 3'b011;
        c.aff = 3'b011;
        c.rrs = 4'b1111;
        c.ars = 3'b111;
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c = '{st: State, oa: RF_OutASel, ob: RF_OutBSel, rff: RF_FunSel, aff: ARF_FunSel,
              rrs: RF_RegSel, rsc: RF_ScrSel, alu: ALU_FunSel, wf: ALU_WF, oc: ARF_OutCSel,
              od: ARF_OutDSel, ars: ARF_RegSel, lh: IR_LH, irw: IR_Write, wr: Mem_WR,
              cs: Mem_CS, ma: MuxASel, mb: MuxBSel, mc: MuxCSel, hl: Halted};
        return c;
    endfunction

    // One clock cycle: queue the expectation, compare mid-cycle, advance past the edge.
    task automatic step(input string tag, input ctl_t e);
        ctl_t  got, want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge Clock);
        got  = sample();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, got, want);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic instr(input string tag, input logic [15:0] ir, input logic [3:0] fl,
                         input ctl_t ex);
        step({tag, "_f0"}, fetch(S_F0, 1'b0));
        step({tag, "_f1"}, fetch(S_F1, 1'b1));
        IROut      = ir;
        ALUOutFlag = fl;
        step({tag, "_ex"}, ex);
    endtask

    initial begin
        ctl_t e;
        Reset      = 1'b1;
        IROut      = 16'h0000;
        ALUOutFlag = 4'h0;
        @(posedge Clock);
        #1;
        step("reset_hold", dflt(S_INIT));
        Reset = 1'b0;
        step("init", init_word());

        e = dflt(S_EX); e.ma = 2'b11; e.rff = 3'b010; e.rrs = 4'b1000;
        instr("ldi_r1", 16'h0005, 4'h0, e);
        instr("hlt", 16'hFC1F, 4'h0, dflt(S_EX));
        e = dflt(S_HALT); e.hl = 1'b1;
        for (int i = 0; i < 20; i++) step("halted", e);

        // Reset out of HALT: outputs drop to defaults while State still reads HALT.
        Reset = 1'b1;
        step("reset_from_halt", dflt(S_HALT));
        step("reset_hold2", dflt(S_INIT));
        Reset = 1'b0;
        step("init2", init_word());

        e = dflt(S_EX); e.ma = 2'b11; e.rff = 3'b010; e.rrs = 4'b1000;
        instr("ldi_r1b", 16'h0005, 4'h0, e);
        e = dflt(S_EX); e.ma = 2'b11; e.rff = 3'b010; e.rrs = 4'b0100;
        instr("ldi_r2", 16'h01FB, 4'h0, e);
        e = dflt(S_EX); e.oa = 3'b000; e.ob = 3'b001; e.alu = 5'b10100; e.wf = 1'b1;
        e.ma = 2'b00; e.rff = 3'b010; e.rrs = 4'b1000;
        instr("add", 16'h1040, 4'h0, e);
        instr("bne_taken_z", 16'h1820, 4'b1000, dflt(S_EX));
        e = dflt(S_EX); e.mb = 2'b11; e.aff = 3'b010; e.ars = 3'b100;
        instr("bne_nz", 16'h1820, 4'b0000, e);
        e = dflt(S_EX); e.mb = 2'b11; e.aff = 3'b010; e.ars = 3'b100;
        instr("bra", 16'h1420, 4'b1000, e);
        e = dflt(S_EX); e.mb = 2'b11; e.aff = 3'b010; e.ars = 3'b010;
        instr("ldar", 16'h0440, 4'h0, e);
        e = dflt(S_EX); e.oa = 3'b000; e.alu = 5'b10000; e.mc = 1'b0; e.od = 2'b01;
        e.cs = 1'b0; e.wr = 1'b1;
        instr("stm_r1", 16'h0C00, 4'h0, e);
        e = dflt(S_EX); e.oa = 3'b010; e.alu = 5'b10000; e.od = 2'b01; e.cs = 1'b0; e.wr = 1'b1;
        instr("stm_r3", 16'h0E00, 4'h0, e);
        e = dflt(S_EX); e.od = 2'b01; e.cs = 1'b0; e.ma = 2'b10; e.rff = 3'b010; e.rrs = 4'b0001;
        instr("ldm_r4", 16'h0B00, 4'h0, e);
        e = dflt(S_EX); e.oa = 3'b011; e.ob = 3'b010; e.alu = 5'b10100; e.wf = 1'b1;
        e.rff = 3'b010; e.rrs = 4'b0001;
        instr("add_r4r3", 16'h1380, 4'h0, e);
        instr("nop_2a", 16'hA800, 4'h0, dflt(S_EX));

        // Reset asserted during F1 aborts the fetch.
        step("abort_f0", fetch(S_F0, 1'b0));
        Reset = 1'b1;
        step("abort_f1", dflt(S_F1));
        Reset = 1'b0;
        step("abort_init", init_word());

        // Reset asserted during an ADD execute cycle suppresses its writes.
        step("abort2_f0", fetch(S_F0, 1'b0));
        step("abort2_f1", fetch(S_F1, 1'b1));
        IROut = 16'h1040;
        Reset = 1'b1;
        step("abort2_ex", dflt(S_EX));
        Reset = 1'b0;
        step("abort2_init", init_word());
        step("restart_f0", fetch(S_F0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
